// File: rtl/cpu_defs.sv
// Shared pipeline definitions: load-type codes, writeback state codes and
// the MEM/WB register layout.
package cpu_defs;

  // Load-type codes carried down the pipeline with every load.
  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // Writeback stage occupancy states.
  localparam logic [1:0] WB_EMPTY = 2'd0;
  localparam logic [1:0] WB_VALID = 2'd1;
  localparam logic [1:0] WB_WAIT  = 2'd2;
  localparam logic [1:0] WB_DRAIN = 2'd3;

  // One retired instruction as held in the MEM/WB register.
  typedef struct packed {
    logic [31:0] pc;
    logic        regwrite;
    logic [4:0]  wa;
    logic [31:0] result;
    logic        is_load;
    logic [2:0]  load_type;
    logic [1:0]  addr_lo;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handoff bundle. The MEM stage is the master, WB the slave.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_pc;
  logic        mem_regwrite;
  logic [4:0]  mem_wa;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;

  modport master (
    output mem_valid, mem_pc, mem_regwrite, mem_wa, mem_result,
           mem_is_load, mem_load_type, mem_addr_lo,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_pc, mem_regwrite, mem_wa, mem_result,
           mem_is_load, mem_load_type, mem_addr_lo,
    output mem_ready
  );
endinterface

// File: rtl/load_formatter.sv
// Combinational load data formatter: picks the byte/halfword addressed by
// addr_lo out of a word-aligned little-endian read and extends it.
module load_formatter
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection then sign/zero extension; unknown codes behave as LW.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // addr_lo[0] is ignored for halfwords; misalignment traps upstream.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  result = {24'd0, byte_sel};
      LT_LH:   result = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one retired instruction, waits for load data,
// drives the register-file write port and the debug writeback trace.
module wb_stage
  import cpu_defs::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_stage_if.slave     mem,
  input  logic          data_ok,
  input  logic [DW-1:0] data_rdata,
  input  logic          flushW,
  output logic          we3,
  output logic [4:0]    wa3,
  output logic [DW-1:0] wd3,
  output logic          stallW,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [4:0]    debug_wb_rf_wnum,
  output logic [DW-1:0] debug_wb_rf_wdata
);

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  wb_entry_t   held_reg;
  wb_entry_t   mem_entry;
  logic        wait_st;
  logic        owed;
  logic        accept;
  logic        commit;
  logic [31:0] load_data;

  assign wait_st = (state_reg == WB_WAIT);
  // A read response is still owed to us, whether or not we keep its data.
  assign owed    = wait_st | (state_reg == WB_DRAIN);

  // While a response is owed the slot frees only in the cycle data returns.
  // Ready is forced low while reset is asserted.
  assign mem.mem_ready = rst & (owed ? data_ok : 1'b1);
  assign accept        = mem.mem_valid & mem.mem_ready & ~flushW;

  // Pack the presented instruction into the MEM/WB register layout.
  always_comb begin
    mem_entry.pc        = mem.mem_pc;
    mem_entry.regwrite  = mem.mem_regwrite;
    mem_entry.wa        = mem.mem_wa;
    mem_entry.result    = mem.mem_result;
    mem_entry.is_load   = mem.mem_is_load;
    mem_entry.load_type = mem.mem_load_type;
    mem_entry.addr_lo   = mem.mem_addr_lo;
  end

  // Next occupancy: hold while data is owed, otherwise refill or empty.
  always_comb begin
    state_next = WB_EMPTY;
    if (owed && !data_ok) begin
      state_next = (wait_st && flushW) ? WB_DRAIN : state_reg;
    end else if (accept) begin
      state_next = mem_entry.is_load ? WB_WAIT : WB_VALID;
    end
  end

  // State and MEM/WB register; the register only changes on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= WB_EMPTY;
      held_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        held_reg <= mem_entry;
      end
    end
  end

  load_formatter u_fmt (
    .rdata     (data_rdata),
    .load_type (held_reg.load_type),
    .addr_lo   (held_reg.addr_lo),
    .result    (load_data)
  );

  // Load data is written in the very cycle data_ok arrives.
  assign commit = ~flushW & ((state_reg == WB_VALID) | (wait_st & data_ok));
  assign we3    = commit & held_reg.regwrite & (held_reg.wa != 5'd0);
  assign wa3    = held_reg.wa;
  assign wd3    = wait_st ? load_data : held_reg.result;
  assign stallW = owed & ~data_ok;

  assign debug_wb_pc       = held_reg.pc;
  assign debug_wb_rf_wen   = {4{we3}};
  assign debug_wb_rf_wnum  = wa3;
  assign debug_wb_rf_wdata = wd3;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan steps followed by
// random traffic, all checked against a slot/owed-response reference model.
module tb_wb_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        flushW;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        stallW;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_stage_if bus ();

  wb_stage #(.DW(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem               (bus),
    .data_ok           (data_ok),
    .data_rdata        (data_rdata),
    .flushW            (flushW),
    .we3               (we3),
    .wa3               (wa3),
    .wd3               (wd3),
    .stallW            (stallW),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an optional held instruction, whether it still waits
  // for data, and whether a flushed load's response is still outstanding.
  logic        m_has, m_ld, m_drain;
  logic [31:0] m_pc, m_res;
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [2:0]  m_lt;
  logic [1:0]  m_al;

  // Expectations of the current cycle, kept for the model update.
  logic        e_ready, e_we;
  logic [31:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  // Load formatting from the ISA rules, using plain integer arithmetic.
  function automatic logic [31:0] fmt_ref(input logic [31:0] w, input logic [2:0] lt,
                                          input logic [1:0] a);
    int unsigned bv, hv;
    bv = (w >> (8 * a)) & 32'hFF;
    hv = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (lt)
      LT_LB:   return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
      LT_LBU:  return bv;
      LT_LH:   return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
      LT_LHU:  return hv;
      default: return w;
    endcase
  endfunction

  task automatic model_clear();
    m_has = 0; m_ld = 0; m_drain = 0;
    m_pc = 0; m_res = 0; m_rw = 0; m_wa = 0; m_lt = 0; m_al = 0;
  endtask

  // Drive one cycle of inputs, then at the falling edge check every output.
  task automatic setin(input logic v, input logic [31:0] pc, input logic rw,
                       input logic [4:0] wa, input logic [31:0] res, input logic ld,
                       input logic [2:0] lt, input logic [1:0] al, input logic dok,
                       input logic [31:0] rd, input logic fl);
    logic owed_m, commit_m;
    bus.mem_valid = v;   bus.mem_pc = pc;        bus.mem_regwrite = rw;
    bus.mem_wa = wa;     bus.mem_result = res;   bus.mem_is_load = ld;
    bus.mem_load_type = lt; bus.mem_addr_lo = al;
    data_ok = dok; data_rdata = rd; flushW = fl;
    @(negedge clk);
    owed_m   = (m_has && m_ld) || m_drain;
    e_ready  = owed_m ? dok : 1'b1;
    commit_m = m_has && !fl && (!m_ld || dok);
    e_data   = m_ld ? fmt_ref(rd, m_lt, m_al) : m_res;
    e_we     = commit_m && m_rw && (m_wa != 0);
    chk("mem_ready", bus.mem_ready, e_ready);
    chk("stallW", stallW, owed_m && !dok);
    chk("we3", we3, e_we);
    chk("wa3", wa3, m_wa);
    chk("debug_pc", debug_wb_pc, m_pc);
    chk("debug_wen", debug_wb_rf_wen, {4{e_we}});
    chk("debug_wnum", debug_wb_rf_wnum, m_wa);
    if (commit_m) begin
      chk("wd3", wd3, e_data);
      chk("debug_wdata", debug_wb_rf_wdata, e_data);
    end
  endtask

  // Advance the model across the clock edge using the inputs of this cycle.
  task automatic endcycle();
    logic acc, drain_n;
    acc     = bus.mem_valid && e_ready && !flushW;
    drain_n = ((m_has && m_ld && flushW) || m_drain) && !data_ok;
    if (e_we) $display("commit pc=%h r%0d <= %h", m_pc, m_wa, e_data);
    if (acc) begin
      m_has = 1; m_ld = bus.mem_is_load; m_pc = bus.mem_pc; m_rw = bus.mem_regwrite;
      m_wa = bus.mem_wa; m_res = bus.mem_result; m_lt = bus.mem_load_type;
      m_al = bus.mem_addr_lo;
    end else if (!(m_has && m_ld && !data_ok && !flushW)) begin
      m_has = 0;
    end
    m_drain = drain_n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dok, input logic [31:0] rd, input logic fl);
    setin(0, 32'h0, 0, 5'd0, 32'h0, 0, LT_LW, 2'd0, dok, rd, fl);
  endtask

  task automatic load_seq(input logic [31:0] pc, input logic [2:0] lt, input logic [1:0] al,
                          input int waits, input logic [31:0] rd, input logic [31:0] exp);
    setin(1, pc, 1, 5'd7, 32'h0, 1, lt, al, 0, 32'h0, 0); endcycle();
    for (int i = 0; i < waits; i++) begin
      idle(0, 32'h0, 0);
      chk("load_stall", stallW, 1'b1);
      endcycle();
    end
    idle(1, rd, 0);
    chk("load_we3", we3, 1'b1);
    chk("load_wd3", wd3, exp);
    chk("load_nostall", stallW, 1'b0);
    endcycle();
  endtask

  initial begin
    model_clear();
    rst = 1'b0;
    bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_regwrite = 0; bus.mem_wa = 0;
    bus.mem_result = 0; bus.mem_is_load = 0; bus.mem_load_type = 0; bus.mem_addr_lo = 0;
    data_ok = 0; data_rdata = 0; flushW = 0;

    // Reset state.
    #2;
    chk("rst_we3", we3, 1'b0);
    chk("rst_wa3", wa3, 5'd0);
    chk("rst_wd3", wd3, 32'h0);
    chk("rst_stall", stallW, 1'b0);
    chk("rst_ready", bus.mem_ready, 1'b0);
    chk("rst_pc", debug_wb_pc, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // ALU write.
    setin(1, 32'h100, 1, 5'd5, 32'h1234_5678, 0, LT_LW, 2'd0, 0, 32'h0, 0); endcycle();
    idle(0, 32'h0, 0);
    chk("alu_we3", we3, 1'b1);
    chk("alu_wa3", wa3, 5'd5);
    chk("alu_wd3", wd3, 32'h1234_5678);
    chk("alu_stall", stallW, 1'b0);
    endcycle();

    // Sub-word loads.
    load_seq(32'h104, LT_LB,  2'd3, 2, 32'h80AA_BBCC, 32'hFFFF_FF80);
    load_seq(32'h108, LT_LBU, 2'd3, 2, 32'h80AA_BBCC, 32'h0000_0080);
    load_seq(32'h10C, LT_LHU, 2'd2, 1, 32'hBEEF_0001, 32'h0000_BEEF);
    load_seq(32'h110, LT_LH,  2'd2, 1, 32'hBEEF_0001, 32'hFFFF_BEEF);
    load_seq(32'h114, LT_LW,  2'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Write to $0 is suppressed.
    setin(1, 32'h118, 1, 5'd0, 32'hFFFF_FFFF, 0, LT_LW, 2'd0, 0, 32'h0, 0); endcycle();
    idle(0, 32'h0, 0);
    chk("r0_we3", we3, 1'b0);
    chk("r0_wen", debug_wb_rf_wen, 4'd0);
    endcycle();

    // Flush in VALID drops the write and blocks acceptance.
    setin(1, 32'h11C, 1, 5'd3, 32'h0000_0033, 0, LT_LW, 2'd0, 0, 32'h0, 0); endcycle();
    setin(1, 32'h120, 1, 5'd4, 32'h0000_0044, 0, LT_LW, 2'd0, 0, 32'h0, 1);
    chk("flushv_we3", we3, 1'b0);
    endcycle();
    idle(0, 32'h0, 0);
    chk("flushv_after", we3, 1'b0);
    endcycle();

    // Flush during WAIT, drain, then accept an ALU op with the stale response.
    setin(1, 32'h124, 1, 5'd6, 32'h0, 1, LT_LW, 2'd0, 0, 32'h0, 0); endcycle();
    setin(1, 32'h128, 1, 5'd8, 32'h0, 0, LT_LW, 2'd0, 0, 32'h0, 1); endcycle();
    idle(0, 32'h0, 0);
    chk("drain_stall", stallW, 1'b1);
    endcycle();
    setin(1, 32'h12C, 1, 5'd9, 32'hCAFE_F00D, 0, LT_LW, 2'd0, 1, 32'h5555_5555, 0);
    chk("drain_we3", we3, 1'b0);
    chk("drain_ready", bus.mem_ready, 1'b1);
    endcycle();
    idle(0, 32'h0, 0);
    chk("drain_next_we3", we3, 1'b1);
    chk("drain_next_wa3", wa3, 5'd9);
    chk("drain_next_wd3", wd3, 32'hCAFE_F00D);
    endcycle();

    // Back-to-back loads: old commits while the new one is accepted.
    setin(1, 32'h130, 1, 5'd10, 32'h0, 1, LT_LBU, 2'd1, 0, 32'h0, 0); endcycle();
    setin(1, 32'h134, 1, 5'd11, 32'h0, 1, LT_LHU, 2'd0, 1, 32'h0000_AB00, 0);
    chk("b2b_wd3", wd3, 32'h0000_00AB);
    endcycle();
    idle(1, 32'h0000_1234, 0);
    chk("b2b_wd3_2", wd3, 32'h0000_1234);
    chk("b2b_wa3_2", wa3, 5'd11);
    endcycle();

    // Reset mid-load, then a stray response is ignored.
    setin(1, 32'h138, 1, 5'd12, 32'h0, 1, LT_LW, 2'd0, 0, 32'h0, 0); endcycle();
    idle(0, 32'h0, 0);
    #1 rst = 1'b0;
    #1;
    chk("mrst_we3", we3, 1'b0);
    chk("mrst_stall", stallW, 1'b0);
    chk("mrst_ready", bus.mem_ready, 1'b0);
    chk("mrst_pc", debug_wb_pc, 32'h0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1, 32'h7777_7777, 0);
    chk("stray_we3", we3, 1'b0);
    chk("stray_stall", stallW, 1'b0);
    endcycle();
    setin(1, 32'h13C, 1, 5'd13, 32'h0BAD_CAFE, 0, LT_LW, 2'd0, 0, 32'h0, 0); endcycle();
    idle(0, 32'h0, 0);
    chk("post_rst_we3", we3, 1'b1);
    chk("post_rst_wd3", wd3, 32'h0BAD_CAFE);
    endcycle();

    // Random traffic; responses only arrive when one is owed, except for
    // occasional spurious pulses that must be ignored.
    for (int i = 0; i < 400; i++) begin
      logic dok, owed_now;
      owed_now = (m_has && m_ld) || m_drain;
      dok = owed_now ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      setin($urandom_range(3) != 0, $urandom, 1'($urandom), 5'($urandom_range(7)), $urandom,
            1'($urandom), 3'($urandom), 2'($urandom), dok, $urandom,
            $urandom_range(9) == 0);
      endcycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
